// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Two-requester round-robin arbiter and access sequencer for a single-port
//   RAM (active-high cs/we/oe, write on posedge, read data on negedge).
//   Each command takes three cycles: IDLE (arbitrate and latch), ACCESS (drive
//   the RAM for one cycle), and RESP (pulse the winner's ack for one cycle).
//
//   Handshake: a client raises <p>_req with <p>_we/<p>_addr/<p>_wdata stable
//   and holds them until <p>_ack. The ack is a single-cycle pulse. Fields are
//   sampled only in IDLE. A req still high during the ack cycle is not a new
//   command. A req still high in the IDLE cycle after that is a new command.
//
// Ports
//   clk, rst_n                   clock, async active-low reset
//   a_req/a_we/a_addr/a_wdata    port A command
//   a_ack, a_rdata               port A completion pulse, read data register
//   b_*                          same as port A, for port B
//   ram_cs/we/oe/addr/wdata      RAM control (registered, never X/Z)
//   ram_rdata                    RAM read data (valid during ACCESS reads)
//   dbg_state                    current FSM state, for observation only
module ram_arbiter #(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          ram_cs,
  output logic          ram_we,
  output logic          ram_oe,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic          ptr_b_q;   // 1 = B was served last
  logic          gnt_b_q;   // winner of the command in flight
  logic          lat_we_q;  // command type of the command in flight
  logic          win_b;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // B wins when it is alone, or when both ask and A was served last.
  always_comb begin
    win_b     = b_req && (!a_req || !ptr_b_q);
    sel_we    = win_b ? b_we    : a_we;
    sel_addr  = win_b ? b_addr  : a_addr;
    sel_wdata = win_b ? b_wdata : a_wdata;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (a_req || b_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_b_q   <= 1'b1;
      gnt_b_q   <= 1'b0;
      lat_we_q  <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state_q)
        IDLE: begin
          if (a_req || b_req) begin
            gnt_b_q  <= win_b;
            lat_we_q <= sel_we;
            ram_cs   <= 1'b1;
            ram_we   <= sel_we;
            ram_oe   <= !sel_we;
            ram_addr <= sel_addr;
            // Write data only moves on writes so the bus stays quiet on reads.
            if (sel_we) ram_wdata <= sel_wdata;
          end
        end
        ACCESS: begin
          ram_cs <= 1'b0;
          ram_we <= 1'b0;
          ram_oe <= 1'b0;
          // The RAM drove read data on the negedge inside ACCESS.
          if (!lat_we_q) begin
            if (gnt_b_q) b_rdata <= ram_rdata;
            else         a_rdata <= ram_rdata;
          end
          a_ack <= !gnt_b_q;
          b_ack <= gnt_b_q;
        end
        RESP: begin
          // Pointer moves only when the ack cycle completes.
          ptr_b_q <= gnt_b_q;
        end
        default: ;
      endcase
    end
  end

endmodule
